// File: rtl/hpi_bus_arbiter.sv
// hpi_bus_arbiter
//   Owns the OTG host-port interface (HPI) pins and shares them between two
//   requesters: req0 (NIOS-side bridge) and req1 (hardware keycode poller).
//   Each accepted request becomes one timed HPI cycle (setup, strobe, hold).
//   After system reset the OTG chip reset is held low for RST_CYCLES cycles.
//
// Ports
//   clk_clk              system clock, rising edge
//   reset_reset          synchronous active-high reset
//   reqN_valid/write/addr/wdata   request from requester N (N = 0, 1)
//   reqN_ready           request accepted this cycle (combinational, IDLE only)
//   reqN_done            one-cycle pulse when N's transaction completes
//   reqN_rdata           last read data for N, held until N's next read completes
//   otg_hpi_*            HPI pad-side signals; the top level builds the tristate
//                        from otg_hpi_data_out / otg_hpi_data_oe
//   otg_hpi_reset_n      OTG chip reset, active low

module hpi_bus_arbiter #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned STROBE_CYCLES = 3,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic        clk_clk,
    input  logic        reset_reset,

    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [1:0]  req0_addr,
    input  logic [15:0] req0_wdata,
    output logic        req0_ready,
    output logic        req0_done,
    output logic [15:0] req0_rdata,

    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [1:0]  req1_addr,
    input  logic [15:0] req1_wdata,
    output logic        req1_ready,
    output logic        req1_done,
    output logic [15:0] req1_rdata,

    output logic [1:0]  otg_hpi_address,
    output logic        otg_hpi_cs_n,
    output logic        otg_hpi_r_n,
    output logic        otg_hpi_w_n,
    output logic [15:0] otg_hpi_data_out,
    output logic        otg_hpi_data_oe,
    input  logic [15:0] otg_hpi_data_in,
    output logic        otg_hpi_reset_n
);

    localparam int unsigned CntW = 16;

    // Counter load values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CntW-1:0] RstLoad    = CntW'(RST_CYCLES - 1);
    localparam logic [CntW-1:0] SetupLoad  = CntW'(SETUP_CYCLES - 1);
    localparam logic [CntW-1:0] StrobeLoad = CntW'(STROBE_CYCLES - 1);
    localparam logic [CntW-1:0] HoldLoad   = CntW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        StRstHold,
        StIdle,
        StSetup,
        StStrobe,
        StHold
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            last_grant_q;  // 0 = req0 granted last, 1 = req1
    logic            owner_q;       // requester owning the current transaction
    logic            write_q;
    logic [15:0]     capture_q;     // read data sampled at the end of STROBE

    logic            gnt0;
    logic            gnt1;
    logic            sel_write;
    logic [1:0]      sel_addr;
    logic [15:0]     sel_wdata;

    // Round-robin on a tie: the requester that did not win last time gets it.
    always_comb begin
        gnt0      = req0_valid && (!req1_valid || last_grant_q);
        gnt1      = req1_valid && (!req0_valid || !last_grant_q);
        sel_write = gnt1 ? req1_write : req0_write;
        sel_addr  = gnt1 ? req1_addr  : req0_addr;
        sel_wdata = gnt1 ? req1_wdata : req0_wdata;
    end

    // Gated by reset so an accept is never advertised on an edge that reset wins.
    assign req0_ready = !reset_reset && (state_q == StIdle) && gnt0;
    assign req1_ready = !reset_reset && (state_q == StIdle) && gnt1;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q          <= StRstHold;
            cnt_q            <= RstLoad;
            last_grant_q     <= 1'b1;
            owner_q          <= 1'b0;
            write_q          <= 1'b0;
            capture_q        <= '0;
            req0_done        <= 1'b0;
            req1_done        <= 1'b0;
            req0_rdata       <= '0;
            req1_rdata       <= '0;
            otg_hpi_address  <= '0;
            otg_hpi_cs_n     <= 1'b1;
            otg_hpi_r_n      <= 1'b1;
            otg_hpi_w_n      <= 1'b1;
            otg_hpi_data_out <= '0;
            otg_hpi_data_oe  <= 1'b0;
            otg_hpi_reset_n  <= 1'b0;
        end else begin
            req0_done <= 1'b0;
            req1_done <= 1'b0;

            case (state_q)
                StRstHold: begin
                    if (cnt_q == '0) begin
                        state_q         <= StIdle;
                        otg_hpi_reset_n <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                StIdle: begin
                    if (gnt0 || gnt1) begin
                        state_q         <= StSetup;
                        cnt_q           <= SetupLoad;
                        owner_q         <= gnt1;
                        last_grant_q    <= gnt1;
                        write_q         <= sel_write;
                        otg_hpi_cs_n    <= 1'b0;
                        otg_hpi_r_n     <= 1'b1;
                        otg_hpi_w_n     <= 1'b1;
                        otg_hpi_address <= sel_addr;
                        otg_hpi_data_oe <= sel_write;
                        if (sel_write) begin
                            otg_hpi_data_out <= sel_wdata;
                        end
                    end
                end

                StSetup: begin
                    if (cnt_q == '0) begin
                        state_q     <= StStrobe;
                        cnt_q       <= StrobeLoad;
                        otg_hpi_r_n <= write_q;
                        otg_hpi_w_n <= !write_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                StStrobe: begin
                    if (cnt_q == '0) begin
                        state_q     <= StHold;
                        cnt_q       <= HoldLoad;
                        capture_q   <= otg_hpi_data_in;
                        otg_hpi_r_n <= 1'b1;
                        otg_hpi_w_n <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                StHold: begin
                    if (cnt_q == '0) begin
                        state_q         <= StIdle;
                        otg_hpi_cs_n    <= 1'b1;
                        otg_hpi_data_oe <= 1'b0;
                        if (owner_q) begin
                            req1_done <= 1'b1;
                            if (!write_q) begin
                                req1_rdata <= capture_q;
                            end
                        end else begin
                            req0_done <= 1'b1;
                            if (!write_q) begin
                                req0_rdata <= capture_q;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                default: begin
                    state_q <= StRstHold;
                    cnt_q   <= RstLoad;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hpi_bus_arbiter.sv
// Directed testbench for hpi_bus_arbiter (RST_CYCLES = 4, other timings default).
module tb_hpi_bus_arbiter;

    logic        clk_clk;
    logic        reset_reset;
    logic        req0_valid, req0_write, req0_ready, req0_done;
    logic [1:0]  req0_addr;
    logic [15:0] req0_wdata, req0_rdata;
    logic        req1_valid, req1_write, req1_ready, req1_done;
    logic [1:0]  req1_addr;
    logic [15:0] req1_wdata, req1_rdata;
    logic [1:0]  otg_hpi_address;
    logic        otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n, otg_hpi_data_oe, otg_hpi_reset_n;
    logic [15:0] otg_hpi_data_out, otg_hpi_data_in;

    int tests_run;
    int tests_failed;

    hpi_bus_arbiter #(
        .RST_CYCLES(4)
    ) dut (
        .clk_clk         (clk_clk),
        .reset_reset     (reset_reset),
        .req0_valid      (req0_valid),
        .req0_write      (req0_write),
        .req0_addr       (req0_addr),
        .req0_wdata      (req0_wdata),
        .req0_ready      (req0_ready),
        .req0_done       (req0_done),
        .req0_rdata      (req0_rdata),
        .req1_valid      (req1_valid),
        .req1_write      (req1_write),
        .req1_addr       (req1_addr),
        .req1_wdata      (req1_wdata),
        .req1_ready      (req1_ready),
        .req1_done       (req1_done),
        .req1_rdata      (req1_rdata),
        .otg_hpi_address (otg_hpi_address),
        .otg_hpi_cs_n    (otg_hpi_cs_n),
        .otg_hpi_r_n     (otg_hpi_r_n),
        .otg_hpi_w_n     (otg_hpi_w_n),
        .otg_hpi_data_out(otg_hpi_data_out),
        .otg_hpi_data_oe (otg_hpi_data_oe),
        .otg_hpi_data_in (otg_hpi_data_in),
        .otg_hpi_reset_n (otg_hpi_reset_n)
    );

    initial begin
        clk_clk = 1'b0;
        forever #5 clk_clk = ~clk_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    // T1: reset values, OTG reset length, no ready before IDLE.
    task automatic test_reset();
        logic [10:0] obs;
        int          low_cnt;
        int          early_ready;
        reset_reset = 1'b1;
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 2'd2; req0_wdata = 16'h1234;
        repeat (3) @(negedge clk_clk);
        obs = {otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n, otg_hpi_data_oe, otg_hpi_reset_n,
               otg_hpi_address, req0_ready, req1_ready, req0_done, req1_done};
        tests_run++;
        if (obs !== 11'b111_0_0_00_0000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b, expected %b", obs, 11'b111_0_0_00_0000);
        end
        tests_run++;
        if ({otg_hpi_data_out, req0_rdata, req1_rdata} !== 48'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h, expected 0",
                     {otg_hpi_data_out, req0_rdata, req1_rdata});
        end
        reset_reset = 1'b0;
        #1;
        low_cnt = 0;
        early_ready = 0;
        for (int i = 0; i < 20; i++) begin
            if (otg_hpi_reset_n !== 1'b0) break;
            low_cnt++;
            if (req0_ready !== 1'b0) early_ready++;
            @(negedge clk_clk);
        end
        tests_run++;
        if (low_cnt != 4) begin
            tests_failed++;
            $display("FAIL otg_reset_len: got %0d, expected 4", low_cnt);
        end
        tests_run++;
        if (early_ready != 0) begin
            tests_failed++;
            $display("FAIL ready_in_rst_hold: got %0d cycles, expected 0", early_ready);
        end
        tests_run++;
        if (req0_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_in_idle: got %b, expected 1", req0_ready);
        end
        req0_valid = 1'b0;
    endtask

    // T2: req0 write addr=2 data=0x1234.
    task automatic test_write();
        logic [8:1] cs_tr, w_tr, r_tr, oe_tr, d0_tr, d1_tr;
        @(negedge clk_clk);
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 2'd2; req0_wdata = 16'h1234;
        #1;
        tests_run++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL write_ready: got %b, expected 10", {req0_ready, req1_ready});
        end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_clk);
            if (c == 1) req0_valid = 1'b0;
            #1;
            cs_tr[c] = otg_hpi_cs_n; w_tr[c] = otg_hpi_w_n; r_tr[c] = otg_hpi_r_n;
            oe_tr[c] = otg_hpi_data_oe; d0_tr[c] = req0_done; d1_tr[c] = req1_done;
            if (c == 1) begin
                tests_run++;
                if ({otg_hpi_address, otg_hpi_data_out} !== {2'd2, 16'h1234}) begin
                    tests_failed++;
                    $display("FAIL write_addr_data: got %h/%h, expected 2/1234",
                             otg_hpi_address, otg_hpi_data_out);
                end
            end
        end
        tests_run++;
        if (cs_tr !== 8'b1100_0000) begin
            tests_failed++; $display("FAIL write_cs_n: got %b, expected 11000000", cs_tr);
        end
        tests_run++;
        if (w_tr !== 8'b1110_0011) begin
            tests_failed++; $display("FAIL write_w_n: got %b, expected 11100011", w_tr);
        end
        tests_run++;
        if (r_tr !== 8'b1111_1111) begin
            tests_failed++; $display("FAIL write_r_n: got %b, expected 11111111", r_tr);
        end
        tests_run++;
        if (oe_tr !== 8'b0011_1111) begin
            tests_failed++; $display("FAIL write_oe: got %b, expected 00111111", oe_tr);
        end
        tests_run++;
        if ({d0_tr, d1_tr} !== {8'b0100_0000, 8'b0}) begin
            tests_failed++;
            $display("FAIL write_done: got %b/%b, expected 01000000/00000000", d0_tr, d1_tr);
        end
    endtask

    // T3: req1 read addr=1, data 0xBEEF during strobe.
    task automatic test_read();
        logic [8:1] r_tr, w_tr, oe_tr, d1_tr, d0_tr;
        @(negedge clk_clk);
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 2'd1; req1_wdata = 16'h0;
        otg_hpi_data_in = 16'h0000;
        #1;
        tests_run++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL read_ready: got %b, expected 01", {req0_ready, req1_ready});
        end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_clk);
            if (c == 1) req1_valid = 1'b0;
            if (c == 3) otg_hpi_data_in = 16'hBEEF;
            if (c == 6) otg_hpi_data_in = 16'h5555;
            #1;
            r_tr[c] = otg_hpi_r_n; w_tr[c] = otg_hpi_w_n; oe_tr[c] = otg_hpi_data_oe;
            d1_tr[c] = req1_done; d0_tr[c] = req0_done;
            if (c == 1) begin
                tests_run++;
                if (otg_hpi_address !== 2'd1) begin
                    tests_failed++;
                    $display("FAIL read_addr: got %0d, expected 1", otg_hpi_address);
                end
            end
            if (c == 7) begin
                tests_run++;
                if ({req1_rdata, req0_rdata} !== {16'hBEEF, 16'h0000}) begin
                    tests_failed++;
                    $display("FAIL read_rdata: got %h/%h, expected beef/0000",
                             req1_rdata, req0_rdata);
                end
            end
        end
        tests_run++;
        if ({r_tr, w_tr} !== {8'b1110_0011, 8'hFF}) begin
            tests_failed++;
            $display("FAIL read_strobes: got %b/%b, expected 11100011/11111111", r_tr, w_tr);
        end
        tests_run++;
        if (oe_tr !== 8'h00) begin
            tests_failed++; $display("FAIL read_oe: got %b, expected 00000000", oe_tr);
        end
        tests_run++;
        if ({d1_tr, d0_tr} !== {8'b0100_0000, 8'b0}) begin
            tests_failed++;
            $display("FAIL read_done: got %b/%b, expected 01000000/00000000", d1_tr, d0_tr);
        end
    endtask

    // T4: both requesters valid continuously; 4 transactions round-robin.
    task automatic test_round_robin();
        logic [3:0] gr, dn;
        int ngr, ndone, gaps, both;
        gr = '0; dn = '0; ngr = 0; ndone = 0; gaps = 0; both = 0;
        @(negedge clk_clk);
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 2'd0; req0_wdata = 16'hAAAA;
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 2'd3; req1_wdata = 16'h5555;
        for (int c = 0; c <= 30; c++) begin
            if (c > 0) @(negedge clk_clk);
            if (ngr >= 4) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            #1;
            if (req0_ready && req1_ready) both++;
            if (req0_ready || req1_ready) begin
                if (ngr < 4) gr[ngr] = req1_ready;
                ngr++;
            end
            if (req0_done || req1_done) begin
                if (ndone < 4) dn[ndone] = req1_done;
                ndone++;
            end
            if (c >= 1 && c <= 27 && otg_hpi_cs_n) gaps++;
        end
        tests_run++;
        if (ngr != 4 || gr !== 4'b1010) begin
            tests_failed++;
            $display("FAIL rr_grants: got %0d grants order %b, expected 4 order 1010", ngr, gr);
        end
        tests_run++;
        if (ndone != 4 || dn !== 4'b1010) begin
            tests_failed++;
            $display("FAIL rr_done: got %0d dones order %b, expected 4 order 1010", ndone, dn);
        end
        tests_run++;
        if (gaps != 3) begin
            tests_failed++;
            $display("FAIL rr_cs_gap: got %0d high cycles, expected 3", gaps);
        end
        tests_run++;
        if (both != 0) begin
            tests_failed++;
            $display("FAIL rr_dual_ready: got %0d, expected 0", both);
        end
    endtask

    // T5: reset asserted during STROBE of a req0 read.
    task automatic test_reset_mid();
        int bad_done;
        bit seen;
        @(negedge clk_clk);
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 2'd1;
        otg_hpi_data_in = 16'h1111;
        #1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_clk);
            if (c == 1) req0_valid = 1'b0;
            #1;
        end
        tests_run++;
        if ({otg_hpi_cs_n, otg_hpi_r_n} !== 2'b00) begin
            tests_failed++;
            $display("FAIL mid_in_strobe: got %b, expected 00", {otg_hpi_cs_n, otg_hpi_r_n});
        end
        reset_reset = 1'b1;
        @(negedge clk_clk);
        #1;
        tests_run++;
        if ({otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_reset_n, req0_done} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL mid_reset_outs: got %b, expected 1100",
                     {otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_reset_n, req0_done});
        end
        reset_reset = 1'b0;
        bad_done = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req0_done || req1_done) bad_done++;
            if (otg_hpi_reset_n === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_clk);
            #1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL mid_reset_release: got reset_n=%b after 20 cycles, expected 1",
                     otg_hpi_reset_n);
        end
        tests_run++;
        if (bad_done != 0) begin
            tests_failed++;
            $display("FAIL mid_no_done: got %0d pulses, expected 0", bad_done);
        end
        tests_run++;
        if ({req0_rdata, req1_rdata} !== 32'h0) begin
            tests_failed++;
            $display("FAIL mid_rdata_cleared: got %h/%h, expected 0000/0000",
                     req0_rdata, req1_rdata);
        end
    endtask

    // T6: req0 read; data_in changes after capture edge.
    task automatic test_read_hold();
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 2'd3;
        otg_hpi_data_in = 16'h0F0F;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_ready: got %b, expected 1", req0_ready);
        end
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_clk);
            if (c == 1) req0_valid = 1'b0;
            if (c == 6) otg_hpi_data_in = 16'hA5A5;
            #1;
            if (c == 7) begin
                tests_run++;
                if ({req0_done, req0_rdata} !== {1'b1, 16'h0F0F}) begin
                    tests_failed++;
                    $display("FAIL hold_done_rdata: got %b/%h, expected 1/0f0f",
                             req0_done, req0_rdata);
                end
            end
            if (c == 10) begin
                tests_run++;
                if ({req0_rdata, req1_rdata} !== {16'h0F0F, 16'h0000}) begin
                    tests_failed++;
                    $display("FAIL hold_rdata_kept: got %h/%h, expected 0f0f/0000",
                             req0_rdata, req1_rdata);
                end
            end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset_reset = 1'b1;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
        otg_hpi_data_in = '0;
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_reset_mid();
        test_read_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
